// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared state encoding and detector threshold for the ones-run path
// Contents:
//   state_t     generator FSM states (ST_IDLE, ST_ONES, ST_GAP)
//   RUN_THRESH  run length at which the detector fires; drives long_run
package seqdet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ONES = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam int RUN_THRESH = 3;

endpackage

// File: rtl/run_down_counter.sv
// rtl/run_down_counter.sv - loadable down-counter with zero flag
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset, clears the count
//   load        in   load load_value (has priority over dec)
//   load_value  in   CNT_W value to load
//   dec         in   decrement by one; holds at zero
//   zero        out  count is zero
module run_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ones_run_generator.sv
// rtl/ones_run_generator.sv - framed ones-burst stimulus source for the consecutive-ones detector
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   start       in   frame request, accepted when start && ready
//   run_len     in   ones per burst (N); 0 = empty frame
//   gap_len     in   zeros after each burst (M); 0 treated as 1
//   repeat_cnt  in   bursts per frame (R); 0 treated as 1
//   ready       out  idle, can accept start
//   x_out       out  registered serial bit stream
//   busy        out  frame in progress (~ready)
//   done        out  one-cycle pulse in the first idle cycle after a frame
//   long_run    out  run_len >= RUN_THRESH for the current/last frame
module ones_run_generator
    import seqdet_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] run_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             ready,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic             long_run
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] THRESH_W = CNT_W'(RUN_THRESH);

    state_t           state_q, state_d;
    logic             x_q, x_d;
    logic             done_q, done_d;
    logic             ready_q;
    logic             long_run_q, long_run_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] gap_q, gap_d;

    logic             phase_load, phase_dec, phase_zero;
    logic [CNT_W-1:0] phase_value;
    logic             burst_load, burst_dec, burst_zero;
    logic [CNT_W-1:0] burst_value;

    // Counters hold "cycles remaining minus one", so zero marks the last
    // cycle of the current phase / the last burst of the frame.
    run_down_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (phase_load),
        .load_value (phase_value),
        .dec        (phase_dec),
        .zero       (phase_zero)
    );

    run_down_counter #(.CNT_W(CNT_W)) u_burst_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (burst_load),
        .load_value (burst_value),
        .dec        (burst_dec),
        .zero       (burst_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            x_q        <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            long_run_q <= 1'b0;
            run_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            done_q     <= done_d;
            ready_q    <= (state_d == ST_IDLE);
            long_run_q <= long_run_d;
            run_q      <= run_d;
            gap_q      <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = 1'b0;
        done_d      = 1'b0;
        long_run_d  = long_run_q;
        run_d       = run_q;
        gap_d       = gap_q;
        phase_load  = 1'b0;
        phase_dec   = 1'b0;
        phase_value = '0;
        burst_load  = 1'b0;
        burst_dec   = 1'b0;
        burst_value = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    run_d       = run_len;
                    gap_d       = gap_len;
                    long_run_d  = (run_len >= THRESH_W);
                    burst_load  = 1'b1;
                    burst_value = (repeat_cnt == '0) ? '0 : (repeat_cnt - CNT_ONE);
                    if (run_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_ONES;
                        x_d         = 1'b1;
                        phase_load  = 1'b1;
                        phase_value = run_len - CNT_ONE;
                    end
                end
            end

            ST_ONES: begin
                if (phase_zero) begin
                    state_d     = ST_GAP;
                    phase_load  = 1'b1;
                    phase_value = (gap_q == '0) ? '0 : (gap_q - CNT_ONE);
                end else begin
                    x_d       = 1'b1;
                    phase_dec = 1'b1;
                end
            end

            ST_GAP: begin
                if (phase_zero) begin
                    if (burst_zero) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_ONES;
                        x_d         = 1'b1;
                        burst_dec   = 1'b1;
                        phase_load  = 1'b1;
                        phase_value = run_q - CNT_ONE;
                    end
                end else begin
                    phase_dec = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready    = ready_q;
    assign busy     = ~ready_q;
    assign x_out    = x_q;
    assign done     = done_q;
    assign long_run = long_run_q;

endmodule

// File: tb/tb_ones_run_generator.sv
// tb/tb_ones_run_generator.sv - self-checking bench for ones_run_generator
module tb_ones_run_generator;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] run_len = '0;
    logic [3:0] gap_len = '0;
    logic [3:0] repeat_cnt = '0;
    logic       ready, x_out, busy, done, long_run;

    ones_run_generator #(.CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .run_len    (run_len),
        .gap_len    (gap_len),
        .repeat_cnt (repeat_cnt),
        .ready      (ready),
        .x_out      (x_out),
        .busy       (busy),
        .done       (done),
        .long_run   (long_run)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: a frame is expanded into its full bit sequence on
    // acceptance and then played out one bit per cycle.
    bit m_q[$];
    bit m_ready = 1'b1;
    bit m_done  = 1'b0;
    bit m_x     = 1'b0;
    bit m_lr    = 1'b0;
    bit m_pend  = 1'b0;

    typedef struct {
        logic [3:0] n, m, r;
        int         cycles;   // accept edge to done cycle
        int         ones;
        int         bursts;
        int         det;      // cycles where the last three bits were all 1
        bit         lr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b1;
        m_done  = 1'b0;
        m_x     = 1'b0;
        m_lr    = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic model_edge(input bit s, input logic [3:0] n, input logic [3:0] m, input logic [3:0] r);
        int rr, mm;
        bit empty_done;
        empty_done = 1'b0;
        if (m_ready && s) begin
            m_lr = (n >= 3);
            if (n == 0) begin
                empty_done = 1'b1;
            end else begin
                rr = (r == 0) ? 1 : int'(r);
                mm = (m == 0) ? 1 : int'(m);
                for (int i = 0; i < rr; i++) begin
                    for (int j = 0; j < int'(n); j++) m_q.push_back(1'b1);
                    for (int j = 0; j < mm; j++) m_q.push_back(1'b0);
                end
            end
        end
        if (m_q.size() > 0) begin
            m_x     = m_q.pop_front();
            m_ready = 1'b0;
            m_done  = 1'b0;
            if (m_q.size() == 0) m_pend = 1'b1;
        end else begin
            m_x     = 1'b0;
            m_ready = 1'b1;
            m_done  = m_pend | empty_done;
            m_pend  = 1'b0;
        end
    endtask

    // One clock: the model sees the inputs that were stable at the edge,
    // outputs are compared 1 ns after the edge.
    task automatic tick();
        bit s;
        logic [3:0] n, m, r;
        s = start; n = run_len; m = gap_len; r = repeat_cnt;
        @(posedge clock);
        if (!reset) model_reset();
        else model_edge(s, n, m, r);
        #1;
        check("outputs{x,ready,busy,done,long_run}",
              {27'd0, x_out, ready, busy, done, long_run},
              {27'd0, m_x, m_ready, !m_ready, m_done, m_lr});
    endtask

    task automatic run_frame(input logic [3:0] n, input logic [3:0] m, input logic [3:0] r,
                             output int cyc, output int ones, output int bursts, output int det);
        bit p1, p2;
        p1 = 1'b0; p2 = 1'b0;
        cyc = 0; ones = 0; bursts = 0; det = 0;
        start = 1'b1; run_len = n; gap_len = m; repeat_cnt = r;
        tick();
        start = 1'b0;
        run_len = 4'($urandom); gap_len = 4'($urandom); repeat_cnt = 4'($urandom);
        for (int k = 1; k <= 600; k++) begin
            if (x_out === 1'b1) begin
                ones++;
                if (!p1) bursts++;
                if (p1 && p2) det++;
            end
            p2 = p1;
            p1 = (x_out === 1'b1);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
            tick();
        end
        if (cyc == 0) check("frame_timeout", 32'd0, 32'd1);
        tick();
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc, ones, bursts, det;

        vecs[0] = '{4'd3,  4'd2,  4'd1,  6,   3,   1,  1,   1'b1};
        vecs[1] = '{4'd2,  4'd0,  4'd3,  10,  6,   3,  0,   1'b0};
        vecs[2] = '{4'd0,  4'd5,  4'd5,  1,   0,   0,  0,   1'b0};
        vecs[3] = '{4'd4,  4'd1,  4'd2,  11,  8,   2,  4,   1'b1};
        vecs[4] = '{4'd15, 4'd15, 4'd15, 451, 225, 15, 195, 1'b1};
        vecs[5] = '{4'd1,  4'd0,  4'd0,  3,   1,   1,  0,   1'b0};
        vecs[6] = '{4'd3,  4'd1,  4'd0,  5,   3,   1,  1,   1'b1};
        vecs[7] = '{4'd5,  4'd3,  4'd2,  17,  10,  2,  6,   1'b1};
        vecs[8] = '{4'd15, 4'd0,  4'd1,  17,  15,  1,  13,  1'b1};

        // Reset state
        tick();
        tick();
        check("reset_state", {27'd0, x_out, ready, busy, done, long_run}, 32'b01000);
        reset = 1'b1;
        tick();

        // Directed frames from the table
        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].n, vecs[i].m, vecs[i].r, cyc, ones, bursts, det);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
            check($sformatf("v%0d_ones", i), ones, vecs[i].ones);
            check($sformatf("v%0d_bursts", i), bursts, vecs[i].bursts);
            check($sformatf("v%0d_detect", i), det, vecs[i].det);
            check($sformatf("v%0d_long_run", i), {31'd0, long_run}, {31'd0, vecs[i].lr});
        end

        // N=0: ready never drops across accept and done
        start = 1'b1; run_len = 4'd0; gap_len = 4'd3; repeat_cnt = 4'd2;
        tick();
        check("empty_ready_kept", {31'd0, ready}, 32'd1);
        start = 1'b0;
        tick();

        // start held high: mid-frame starts ignored, next frame right after done
        start = 1'b1; run_len = 4'd4; gap_len = 4'd1; repeat_cnt = 4'd2;
        tick();
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin cyc = k; break; end
            tick();
        end
        check("held_first_done", cyc, 11);
        tick();
        check("b2b_second_frame_x", {31'd0, x_out}, 32'd1);
        start = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin cyc = k; break; end
            tick();
        end
        check("held_second_done", cyc, 11);
        tick();

        // Asynchronous reset in the middle of a burst
        start = 1'b1; run_len = 4'd8; gap_len = 4'd1; repeat_cnt = 4'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_ones_x", {31'd0, x_out}, 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_reset_outputs", {27'd0, x_out, ready, busy, done, long_run}, 32'b01000);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) tick();

        // Randomized traffic against the model
        for (int k = 0; k < 2500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 30) == 0) begin
                run_len = 4'd15; gap_len = 4'($urandom); repeat_cnt = 4'($urandom_range(0, 3));
            end else begin
                run_len = 4'($urandom_range(0, 6));
                gap_len = 4'($urandom_range(0, 3));
                repeat_cnt = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 400) == 0) begin
                #2 reset = 1'b0;
                #1 model_reset();
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
